div_sched: RTL
==============

Name: div_sched

Overview:
- Sequencer for an iterative 32-bit radix-2 restoring divider that serves DIV/DIVU in the execute stage.
- Latches the operands, runs 32 shift-subtract iterations and holds the pipeline with a stall request while busy.
- Presents the HI (remainder) and LO (quotient) pair for one cycle, which the HI/LO write path consumes.
- Sits beside the E-stage ALU; start comes from the decoded divide control, and cancel comes from the E-stage flush.

Parameters:
- WIDTH, 32, operand and result width.
- ITERS, 32, shift-subtract iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- startE  in  1  divide instruction present in E stage.
- signedE  in  1  1 = DIV (signed), 0 = DIVU.
- opaE  in  WIDTH  dividend (rs).
- opbE  in  WIDTH  divisor (rt).
- cancelE  in  1  flush of E stage; aborts any operation.
- stall_divE  out  1  pipeline stall request, combinational.
- hi_o  out  WIDTH  remainder; registered.
- lo_o  out  WIDTH  quotient; registered.
- result_valid  out  1  one-cycle strobe; hi_o/lo_o are valid in that cycle.

Behaviour:
- Reset values: state=IDLE, count=0, hi_o=0, lo_o=0, result_valid=0. stall_divE=0 while rst=1.
- States:
  - IDLE → BUSY when startE & !cancelE & opbE!=0. Operands are latched on that edge.
  - IDLE → ZERO when startE & !cancelE & opbE==0.
  - BUSY: one iteration per cycle, count 0..31. After the iteration with count==31 → DONE.
  - ZERO → DONE after 1 cycle. Iterations are skipped.
  - DONE → IDLE unconditionally. result_valid=1 in DONE only.
- Stall: stall_divE = (IDLE & startE & !cancelE) | BUSY | ZERO. It is 0 in DONE so E advances exactly once with the result.
- startE still asserted in the DONE cycle (the same instruction) must not retrigger. Only IDLE samples startE.
- Latency, start in cycle 0:
  - Normal divide: stall high cycles 0..32, result_valid in cycle 33.
  - Divide by zero: stall high cycles 0..1, result_valid in cycle 2.
- Operand conditioning at latch: if signedE, use the magnitudes of opaE/opbE. Record qneg = sa^sb and rneg = sa.
- Iteration: 64-bit {rem,quo} register shifts left by 1. If rem_upper >= divisor, subtract and set quotient LSB to 1. Comparison uses WIDTH+1 bits so there is no overflow.
- Final fix-up on DONE entry: lo = qneg ? -quo : quo; hi = rneg ? -rem : rem. Arithmetic is two's-complement modulo 2^WIDTH.
- Divide by zero: lo_o = 32'hFFFF_FFFF, hi_o = opaE as latched (raw, not sign-adjusted).
- 0x8000_0000 / 0xFFFF_FFFF signed: lo_o = 0x8000_0000, hi_o = 0. Falls out of the modulo arithmetic; no trap.
- cancelE in any state → IDLE next edge, count=0, no result_valid. stall_divE drops in the same cycle because the terms are gated.
- cancelE in DONE: result_valid still asserts (already committed); state → IDLE.
- rst mid-BUSY: IDLE next edge, outputs at reset values, no strobe.
- hi_o/lo_o hold their last value outside DONE.

Decomposition:
- Shared package holds the state encoding (IDLE, BUSY, ZERO, DONE; 2 bits), DIV_ITERS=32 and the DIV0_LO constant 32'hFFFF_FFFF.
- Sub-module div_step: a combinational single shift-subtract step taking {rem,quo} and divisor and returning the next {rem,quo}.
- div_sched owns the FSM, counter, operand latch, sign fix-up and the stall/strobe logic.

Test Plan:
- Unsigned 100/7: start cycle 0 → stall high cycles 0..32; cycle 33 result_valid=1, lo_o=14, hi_o=2.
- Signed -7 (0xFFFF_FFF9) / 2 → lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF. DIVU on the same operands → lo_o=0x7FFF_FFFC, hi_o=1.
- Divide by zero, opaE=0x1234: stall cycles 0..1, result_valid in cycle 2, lo_o=0xFFFF_FFFF, hi_o=0x1234.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF signed → lo_o=0x8000_0000, hi_o=0, result_valid in cycle 33.
- cancelE pulsed at cycle 10 of BUSY → stall_divE=0 in cycle 10, no result_valid ever. A new start at cycle 12 completes normally in cycle 45.
- rst asserted at cycle 5 of BUSY → stall 0, hi_o/lo_o=0 from next edge. Holding startE continuously: exactly one result_valid per operation, with no retrigger in DONE.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state encoding and constants for the iterative divider
package div_sched_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;
    localparam int DIV_ITERS = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step on the {rem,quo} accumulator
module div_step
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_div,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0] w_top;
    logic [WIDTH:0] w_diff;
    // Shifted remainder keeps its carry-out bit so the compare never overflows
    always_comb begin
        w_top  = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_top - {1'b0, i_div};
        o_acc  = w_diff[WIDTH] ? {i_acc[2*WIDTH-2:0], 1'b0}
                               : {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end
endmodule

// File: rtl/div_sched.sv
// div_sched: FSM sequencing a 32-iteration restoring divide with stall and result strobe
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = DIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             cancelE,
    output logic             stall_divE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             result_valid
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t             r_state, w_nstate;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc, w_next;
    logic [WIDTH-1:0]   r_div, r_raw;
    logic               r_qneg, r_rneg;
    logic               w_sa, w_sb, w_latch, w_last;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_div (r_div),
        .o_acc (w_next)
    );

    // State register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_nstate;
    end

    // Next state, stall request and strobe; cancel forces IDLE and gates the stall
    always_comb begin
        w_nstate = cancelE ? IDLE :
                   r_state == IDLE ? (startE ? (opbE == '0 ? ZERO : BUSY) : IDLE) :
                   r_state == BUSY ? (r_count == LAST ? DONE : BUSY) :
                   r_state == ZERO ? DONE : IDLE;
        stall_divE = !rst && !cancelE &&
                     ((r_state == IDLE && startE) || r_state == BUSY || r_state == ZERO);
        result_valid = r_state == DONE;
        w_sa    = signedE & opaE[WIDTH-1];
        w_sb    = signedE & opbE[WIDTH-1];
        w_mag_a = w_sa ? -opaE : opaE;
        w_mag_b = w_sb ? -opbE : opbE;
        w_latch = r_state == IDLE && startE && !cancelE;
        w_last  = r_state == BUSY && r_count == LAST && !cancelE;
    end

    // Operand latch, iteration datapath and result fix-up on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_acc   <= '0;
            r_div   <= '0;
            r_raw   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            r_count <= (r_state == BUSY && !cancelE) ? r_count + 1'b1 : '0;
            if (w_latch) begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                r_div  <= w_mag_b;
                r_raw  <= opaE;
                r_qneg <= w_sa ^ w_sb;
                r_rneg <= w_sa;
            end else if (r_state == BUSY) begin
                r_acc <= w_next;
            end
            if (w_last) begin
                lo_o <= r_qneg ? -w_next[WIDTH-1:0] : w_next[WIDTH-1:0];
                hi_o <= r_rneg ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];
            end else if (r_state == ZERO && !cancelE) begin
                lo_o <= WIDTH'(DIV0_LO);
                hi_o <= r_raw;
            end
        end
    end
endmodule
